// File: rtl/eth_wrr_sched_pkg.sv
// Shared helpers for the Ethernet frame-level weighted round-robin scheduler.
package eth_wrr_sched_pkg;

  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Rotating priority encoder: first set request bit at or after start, wrapping.
module eth_rr_pick #(
  parameter int S_COUNT = 4,
  parameter int IDX_W   = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0] request,
  input  logic [IDX_W-1:0]   start,
  output logic [S_COUNT-1:0] onehot,
  output logic [IDX_W-1:0]   enc,
  output logic               valid
);

  always_comb begin
    int cand;
    cand  = 0;
    enc   = '0;
    valid = 1'b0;
    // Walk from the farthest candidate back to start so the nearest one wins.
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      cand = int'(start) + i;
      if (cand >= S_COUNT) cand = cand - S_COUNT;
      if (request[IDX_W'(cand)]) begin
        valid = 1'b1;
        enc   = IDX_W'(cand);
      end
    end
    onehot = valid ? (S_COUNT'(1) << enc) : '0;
  end

endmodule

// File: rtl/eth_wrr_sched.sv
// Frame-level weighted round-robin arbiter with acknowledge release and a
// grant watchdog that reports (but never revokes) over-long frames.
module eth_wrr_sched
  import eth_wrr_sched_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [S_COUNT-1:0]                request,
  input  logic [S_COUNT-1:0]                acknowledge,
  input  logic                              enable,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0]   cfg_weight,
  input  logic [TIMEOUT_WIDTH-1:0]          cfg_timeout,
  output logic [S_COUNT-1:0]                grant,
  output logic                              grant_valid,
  output logic [$clog2(S_COUNT)-1:0]        grant_encoded,
  output logic                              timeout_pulse,
  output logic [$clog2(S_COUNT)-1:0]        timeout_port
);

  localparam int IDX_W = $clog2(S_COUNT);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e                state, state_n;
  logic [S_COUNT-1:0]    grant_n, pick_onehot;
  logic                  grant_valid_n, pick_valid, hold;
  logic [IDX_W-1:0]      grant_encoded_n, last_port, last_port_n, timeout_port_n;
  logic [IDX_W-1:0]      start_idx, pick_enc, sel_idx;
  logic [WEIGHT_WIDTH-1:0]  credit, credit_n, sel_weight;
  logic [TIMEOUT_WIDTH-1:0] wd, wd_n, wd_inc;
  logic                  fired, fired_n, timeout_pulse_n;

  assign start_idx  = IDX_W'(wrap_next(32'(last_port), S_COUNT));
  assign hold       = (credit != '0) && request[last_port];
  assign sel_idx    = hold ? last_port : pick_enc;
  assign sel_weight = cfg_weight[sel_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign wd_inc     = (wd == '1) ? wd : wd + 1'b1;

  eth_rr_pick #(.S_COUNT(S_COUNT), .IDX_W(IDX_W)) u_pick (
    .request (request),
    .start   (start_idx),
    .onehot  (pick_onehot),
    .enc     (pick_enc),
    .valid   (pick_valid)
  );

  always_comb begin
    state_n         = state;
    grant_n         = grant;
    grant_valid_n   = grant_valid;
    grant_encoded_n = grant_encoded;
    credit_n        = credit;
    last_port_n     = last_port;
    wd_n            = wd;
    fired_n         = fired;
    timeout_pulse_n = 1'b0;
    timeout_port_n  = timeout_port;
    case (state)
      IDLE: begin
        if (enable && pick_valid) begin
          state_n         = GRANT;
          grant_n         = hold ? (S_COUNT'(1) << last_port) : pick_onehot;
          grant_valid_n   = 1'b1;
          grant_encoded_n = sel_idx;
          wd_n            = '0;
          fired_n         = 1'b0;
          if (hold) begin
            credit_n = credit - 1'b1;
          end else begin
            // Weight 0 behaves as 1, so the fresh credit never underflows.
            credit_n    = (sel_weight == '0) ? '0 : sel_weight - 1'b1;
            last_port_n = sel_idx;
          end
        end
      end
      GRANT: begin
        if (acknowledge[grant_encoded]) begin
          state_n       = IDLE;
          grant_n       = '0;
          grant_valid_n = 1'b0;
        end else begin
          wd_n = wd_inc;
          if ((cfg_timeout != '0) && !fired && (wd_inc == cfg_timeout)) begin
            timeout_pulse_n = 1'b1;
            timeout_port_n  = grant_encoded;
            fired_n         = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      credit        <= '0;
      last_port     <= IDX_W'(S_COUNT - 1);
      wd            <= '0;
      fired         <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_port  <= '0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      grant_valid   <= grant_valid_n;
      grant_encoded <= grant_encoded_n;
      credit        <= credit_n;
      last_port     <= last_port_n;
      wd            <= wd_n;
      fired         <= fired_n;
      timeout_pulse <= timeout_pulse_n;
      timeout_port  <= timeout_port_n;
    end
  end

endmodule

// File: tb/tb_eth_wrr_sched.sv
// Directed bench for eth_wrr_sched: vector table plus hand sequences for
// watchdog timing and asynchronous reset.
module tb_eth_wrr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  request;
  logic [3:0]  acknowledge;
  logic        enable;
  logic [15:0] cfg_weight;
  logic [15:0] cfg_timeout;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_encoded;
  logic        timeout_pulse;
  logic [1:0]  timeout_port;

  int n_vec = 0;
  int n_bad = 0;

  eth_wrr_sched #(.S_COUNT(4), .WEIGHT_WIDTH(4), .TIMEOUT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .request       (request),
    .acknowledge   (acknowledge),
    .enable        (enable),
    .cfg_weight    (cfg_weight),
    .cfg_timeout   (cfg_timeout),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_encoded (grant_encoded),
    .timeout_pulse (timeout_pulse),
    .timeout_port  (timeout_port)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic        do_rst;
    logic [15:0] weight;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        en;
    logic        exp_valid;
    logic [1:0]  exp_enc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [15:0] w, input logic [3:0] rq,
                              input logic [3:0] ak, input logic e, input logic ev,
                              input logic [1:0] ee);
    vec_t v;
    v = '{do_rst: r, weight: w, req: rq, ack: ak, en: e, exp_valid: ev, exp_enc: ee};
    vecs.push_back(v);
  endfunction

  // driver tasks
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_grant(input string name, input logic ev, input logic [1:0] ee);
    logic [3:0] eg;
    eg = ev ? (4'b0001 << ee) : 4'b0000;
    check({name, ".valid"}, 32'(grant_valid), 32'(ev));
    check({name, ".grant"}, 32'(grant), 32'(eg));
    if (ev) check({name, ".enc"}, 32'(grant_encoded), 32'(ee));
  endtask

  localparam logic [15:0] W_A = 16'h1112;  // port0 weight 2, others 1
  localparam logic [15:0] W_B = 16'h1101;  // port1 weight 0
  localparam logic [15:0] W_1 = 16'h1111;

  initial begin
    rst_n       = 1'b0;
    request     = '0;
    acknowledge = '0;
    enable      = 1'b0;
    cfg_weight  = W_1;
    cfg_timeout = '0;

    // weighted order 0,0,1,2,3,0,0,1 with ack one cycle after each grant
    add(1, W_A, 4'hF, 4'h0, 1, 1, 2'd0);
    add(0, W_A, 4'hF, 4'h1, 1, 0, 2'd0);
    add(0, W_A, 4'hF, 4'h0, 1, 1, 2'd0);
    add(0, W_A, 4'hF, 4'h1, 1, 0, 2'd0);
    add(0, W_A, 4'hF, 4'h0, 1, 1, 2'd1);
    add(0, W_A, 4'h0, 4'h1, 1, 1, 2'd1);  // foreign ack, request drop: held
    add(0, W_A, 4'hF, 4'h2, 1, 0, 2'd0);
    add(0, W_A, 4'hF, 4'h0, 1, 1, 2'd2);
    add(0, W_A, 4'hF, 4'h4, 1, 0, 2'd0);
    add(0, W_A, 4'hF, 4'h0, 1, 1, 2'd3);
    add(0, W_A, 4'hF, 4'h8, 1, 0, 2'd0);
    add(0, W_A, 4'hF, 4'h0, 1, 1, 2'd0);
    add(0, W_A, 4'hF, 4'h1, 1, 0, 2'd0);
    add(0, W_A, 4'hF, 4'h0, 1, 1, 2'd0);
    add(0, W_A, 4'hF, 4'h1, 1, 0, 2'd0);
    add(0, W_A, 4'hF, 4'h0, 1, 1, 2'd1);
    add(0, W_A, 4'hF, 4'h0, 0, 1, 2'd1);  // enable low does not revoke
    add(0, W_A, 4'hF, 4'h2, 1, 0, 2'd0);
    // weight 0 acts as 1: order 1,2,1,2
    add(1, W_B, 4'h6, 4'h0, 1, 1, 2'd1);
    add(0, W_B, 4'h6, 4'h2, 1, 0, 2'd0);
    add(0, W_B, 4'h6, 4'h0, 1, 1, 2'd2);
    add(0, W_B, 4'h6, 4'h4, 1, 0, 2'd0);
    add(0, W_B, 4'h6, 4'h0, 1, 1, 2'd1);
    add(0, W_B, 4'h6, 4'h2, 1, 0, 2'd0);
    add(0, W_B, 4'h6, 4'h0, 1, 1, 2'd2);
    // single requester: one-cycle gap then regrant
    add(1, W_1, 4'h4, 4'h0, 1, 1, 2'd2);
    add(0, W_1, 4'h4, 4'h4, 1, 0, 2'd0);
    add(0, W_1, 4'h4, 4'h0, 1, 1, 2'd2);
    // enable gating
    add(1, W_1, 4'hF, 4'h0, 0, 0, 2'd0);
    add(0, W_1, 4'hF, 4'h0, 0, 0, 2'd0);
    add(0, W_1, 4'hF, 4'h0, 0, 0, 2'd0);
    add(0, W_1, 4'hF, 4'h0, 1, 1, 2'd0);

    apply_reset();
    check("reset.grant", 32'(grant), 32'd0);
    check("reset.valid", 32'(grant_valid), 32'd0);
    check("reset.enc", 32'(grant_encoded), 32'd0);
    check("reset.pulse", 32'(timeout_pulse), 32'd0);
    check("reset.tport", 32'(timeout_port), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) apply_reset();
      cfg_weight  = vecs[i].weight;
      request     = vecs[i].req;
      acknowledge = vecs[i].ack;
      enable      = vecs[i].en;
      step();
      check_grant($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_enc);
      check($sformatf("vec%0d.pulse", i), 32'(timeout_pulse), 32'd0);
    end

    // watchdog: pulse after the 10th clock edge spent in GRANT, grant kept
    request = '0; acknowledge = '0; enable = 1'b0;
    apply_reset();
    cfg_weight = W_1; cfg_timeout = 16'd10; request = 4'h4; enable = 1'b1;
    step();
    check_grant("wd.issue", 1'b1, 2'd2);
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("wd.early%0d", k), 32'(timeout_pulse), 32'd0);
    end
    step();
    check("wd.pulse", 32'(timeout_pulse), 32'd1);
    check("wd.tport", 32'(timeout_port), 32'd2);
    check_grant("wd.kept", 1'b1, 2'd2);
    step();
    check("wd.pulse_end", 32'(timeout_pulse), 32'd0);
    check("wd.tport_hold", 32'(timeout_port), 32'd2);
    begin
      int extra;
      extra = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (timeout_pulse) extra++;
      end
      check("wd.once", 32'(extra), 32'd0);
    end
    acknowledge = 4'h4; request = '0;
    step();
    check_grant("wd.ack", 1'b0, 2'd0);
    acknowledge = '0;

    // ack on the timeout edge wins: no pulse
    apply_reset();
    request = 4'h2;
    step();
    check_grant("wdack.issue", 1'b1, 2'd1);
    repeat (9) step();
    acknowledge = 4'h2;
    step();
    check("wdack.pulse", 32'(timeout_pulse), 32'd0);
    check("wdack.tport", 32'(timeout_port), 32'd0);
    check_grant("wdack.release", 1'b0, 2'd0);
    acknowledge = '0; request = '0;
    step();
    check("wdack.late", 32'(timeout_pulse), 32'd0);

    // async reset mid-grant to port 3, next grant from port 0
    cfg_timeout = '0;
    apply_reset();
    request = 4'hF;
    for (int p = 0; p < 3; p++) begin
      acknowledge = '0;
      step();
      check_grant($sformatf("rst.seq%0d", p), 1'b1, 2'(p));
      acknowledge = 4'b0001 << p;
      step();
    end
    acknowledge = '0;
    step();
    check_grant("rst.port3", 1'b1, 2'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rst.async_grant", 32'(grant), 32'd0);
    check("rst.async_valid", 32'(grant_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_grant("rst.after", 1'b1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
